// File: rtl/jtkicker_intctl.sv
// Interrupt and control-latch block for the main CPU: masked edge-triggered
// channels with frame prescalers, write-1-to-clear acknowledge, control latch and watchdog.
module jtkicker_intctl #(
    parameter int unsigned     CH       = 2,
    parameter logic [CH*4-1:0] TRIG_DIV = '0,
    parameter int unsigned     WDOG_W   = 16,
    parameter bit              WDOG_EN  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic          cs,
    input  logic          wr,
    input  logic [1:0]    addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    input  logic [CH-1:0] trig,
    output logic [CH-1:0] int_n,
    output logic [7:0]    ctrl,
    output logic          wdog_rst
);

    localparam int unsigned DW = 4;

    logic [CH-1:0] mask, mask_nxt;
    logic [CH-1:0] pend, pend_nxt;
    logic [CH-1:0] trig_l, qual, ack;
    logic [DW-1:0] divcnt     [CH];
    logic [DW-1:0] divcnt_nxt [CH];
    logic [7:0]    ctrl_nxt, dout_nxt;
    logic          reg_we;

    // Register writes, edge qualification and per-channel set/clear priority
    always_comb begin
        reg_we   = cs & wr & cpu_cen;
        mask_nxt = mask;
        ctrl_nxt = ctrl;
        ack      = '0;
        if (reg_we) begin
            case (addr)
                2'd0:    mask_nxt = din[CH-1:0];
                2'd1:    ctrl_nxt = din;
                2'd2:    ack      = din[CH-1:0];
                default: ;
            endcase
        end
        qual = trig & ~trig_l & mask;
        pend = ~int_n;
        for (int k = 0; k < CH; k++) begin
            pend_nxt[k]   = pend[k];
            divcnt_nxt[k] = divcnt[k];
            // Masking (including a mask cleared on this very write) overrides everything
            if (!mask_nxt[k]) begin
                pend_nxt[k]   = 1'b0;
                divcnt_nxt[k] = '0;
            end else if (qual[k] && divcnt[k] == TRIG_DIV[DW*k +: DW]) begin
                pend_nxt[k]   = 1'b1;
                divcnt_nxt[k] = '0;
            end else begin
                if (qual[k]) divcnt_nxt[k] = DW'(divcnt[k] + 4'd1);
                if (ack[k])  pend_nxt[k]   = 1'b0;
            end
        end
    end

    // Read mux; unused upper bits read back as ones
    always_comb begin
        dout_nxt = 8'hFF;
        if (cs && !wr) begin
            case (addr)
                2'd0:    dout_nxt[CH-1:0] = mask;
                2'd1:    dout_nxt[CH-1:0] = pend;
                2'd2:    dout_nxt         = ctrl;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask   <= '0;
            ctrl   <= '0;
            int_n  <= '1;
            trig_l <= '0;
            dout   <= 8'hFF;
            for (int k = 0; k < CH; k++) divcnt[k] <= '0;
        end else begin
            mask   <= mask_nxt;
            ctrl   <= ctrl_nxt;
            int_n  <= ~pend_nxt;
            trig_l <= trig;
            dout   <= dout_nxt;
            for (int k = 0; k < CH; k++) divcnt[k] <= divcnt_nxt[k];
        end
    end

    generate
        if (WDOG_EN) begin : g_wdog
            logic [WDOG_W-1:0] wcnt;
            logic              wdog_q;
            logic              kick;

            assign kick     = cs & wr & cpu_cen & (addr == 2'd3);
            assign wdog_rst = wdog_q;

            // Kick takes precedence over counting; expiry wraps the counter
            always_ff @(posedge clk) begin
                if (rst) begin
                    wcnt   <= '0;
                    wdog_q <= 1'b0;
                end else begin
                    wdog_q <= 1'b0;
                    if (cpu_cen) begin
                        if (kick) begin
                            wcnt <= '0;
                        end else if (&wcnt) begin
                            wcnt   <= '0;
                            wdog_q <= 1'b1;
                        end else begin
                            wcnt <= WDOG_W'(wcnt + WDOG_W'(1));
                        end
                    end
                end
            end
        end else begin : g_no_wdog
            assign wdog_rst = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_jtkicker_intctl.sv
// Bench for jtkicker_intctl: directed vector table, prescaler/watchdog sequences and
// randomized traffic against an edge-counting reference model of two instances.
module tb_jtkicker_intctl;

    logic       clk = 1'b0;
    logic       rst, cpu_cen, cs, wr;
    logic [1:0] addr;
    logic [7:0] din;
    logic [1:0] trig;
    logic [7:0] dout0, dout1, ctrl0, ctrl1;
    logic [1:0] int_n0, int_n1;
    logic       wd0, wd1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtkicker_intctl #(.CH(2), .TRIG_DIV(8'h00), .WDOG_W(4), .WDOG_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cs(cs), .wr(wr), .addr(addr),
        .din(din), .dout(dout0), .trig(trig), .int_n(int_n0), .ctrl(ctrl0), .wdog_rst(wd0));

    // Channel 0 every 4th edge, channel 1 every 2nd edge
    jtkicker_intctl #(.CH(2), .TRIG_DIV(8'h13), .WDOG_W(4), .WDOG_EN(1'b1)) u1 (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cs(cs), .wr(wr), .addr(addr),
        .din(din), .dout(dout1), .trig(trig), .int_n(int_n1), .ctrl(ctrl1), .wdog_rst(wd1));

    // Reference model: counts qualifying edges since the last clear
    logic [1:0] m_mask, m_tprev;
    logic [7:0] m_ctrl;
    logic [1:0] m_pend [2];
    int         m_cnt  [2][2];
    logic [7:0] m_dout [2];
    int         m_w;
    logic       m_wd;

    function automatic int div_of(int i, int k);
        if (i == 0) return 0;
        return (k == 0) ? 3 : 1;
    endfunction

    task automatic model_reset();
        m_mask = '0; m_tprev = '0; m_ctrl = '0; m_w = 0; m_wd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = '0;
            m_dout[i] = 8'hFF;
            for (int k = 0; k < 2; k++) m_cnt[i][k] = 0;
        end
    endtask

    task automatic model_step();
        logic       we;
        logic [1:0] nm;
        logic       rising, ackb;
        if (rst) begin
            model_reset();
            return;
        end
        we = cs & wr & cpu_cen;
        for (int i = 0; i < 2; i++) begin
            m_dout[i] = 8'hFF;
            if (cs && !wr) begin
                case (addr)
                    2'd0: m_dout[i] = {6'h3F, m_mask};
                    2'd1: m_dout[i] = {6'h3F, m_pend[i]};
                    2'd2: m_dout[i] = m_ctrl;
                    default: m_dout[i] = 8'hFF;
                endcase
            end
        end
        nm = (we && addr == 2'd0) ? din[1:0] : m_mask;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                rising = trig[k] && !m_tprev[k] && m_mask[k];
                ackb   = we && addr == 2'd2 && din[k];
                if (!nm[k]) begin
                    m_pend[i][k] = 1'b0;
                    m_cnt[i][k]  = 0;
                end else begin
                    if (rising) m_cnt[i][k]++;
                    if (rising && m_cnt[i][k] > div_of(i, k)) begin
                        m_pend[i][k] = 1'b1;
                        m_cnt[i][k]  = 0;
                    end else if (ackb) begin
                        m_pend[i][k] = 1'b0;
                    end
                end
            end
        end
        m_mask  = nm;
        m_tprev = trig;
        if (we && addr == 2'd1) m_ctrl = din;
        m_wd = 1'b0;
        if (cpu_cen) begin
            if (we && addr == 2'd3) m_w = 0;
            else begin
                m_w++;
                if (m_w == 16) begin
                    m_w  = 0;
                    m_wd = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [18:0] got, exp;
        for (int i = 0; i < 2; i++) begin
            got = (i == 0) ? {int_n0, ctrl0, dout0, wd0} : {int_n1, ctrl1, dout1, wd1};
            exp = {~m_pend[i], m_ctrl, m_dout[i], m_wd};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model_u%0d t=%0t got {int_n,ctrl,dout,wdog}=%h want %h", i, $time, got, exp);
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, got, exp);
        end
    endtask

    // One clock: model advances on the same inputs the DUT samples
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        cs = 1'b0; wr = 1'b0; addr = 2'd0; din = 8'h00;
    endtask

    task automatic wreg(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; din = d;
        cyc();
        idle();
    endtask

    task automatic pulse0(input string name, input logic exp_int);
        trig[0] = 1'b1;
        cyc();
        chk(name, {7'd0, int_n1[0]}, {7'd0, exp_int});
        trig[0] = 1'b0;
        cyc();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       cs, wr;
        logic [1:0] addr;
        logic [7:0] din;
        logic [1:0] trig;
        logic [1:0] e_int;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl [23];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 8'h03, 2'b00, 2'b11, 8'hFF};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'b01, 2'b10, 8'hFF};
        tbl[2]  = '{1'b1, 1'b0, 2'd1, 8'h00, 2'b00, 2'b10, 8'hFD};
        tbl[3]  = '{1'b1, 1'b1, 2'd2, 8'h01, 2'b00, 2'b11, 8'hFF};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'b10, 2'b01, 8'hFF};
        tbl[5]  = '{1'b1, 1'b1, 2'd2, 8'h02, 2'b10, 2'b11, 8'hFF};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'b10, 2'b11, 8'hFF};
        tbl[7]  = '{1'b1, 1'b1, 2'd1, 8'hA5, 2'b00, 2'b11, 8'hFF};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 8'h01, 2'b01, 2'b10, 8'hFF};
        tbl[9]  = '{1'b1, 1'b0, 2'd2, 8'h00, 2'b00, 2'b10, 8'hA5};
        tbl[10] = '{1'b1, 1'b1, 2'd0, 8'h01, 2'b00, 2'b10, 8'hFF};
        tbl[11] = '{1'b1, 1'b0, 2'd0, 8'h00, 2'b10, 2'b10, 8'hFD};
        tbl[12] = '{1'b1, 1'b0, 2'd3, 8'h00, 2'b00, 2'b10, 8'hFF};
        tbl[13] = '{1'b1, 1'b1, 2'd0, 8'h00, 2'b00, 2'b11, 8'hFF};
        tbl[14] = '{1'b1, 1'b1, 2'd0, 8'h02, 2'b00, 2'b11, 8'hFF};
        tbl[15] = '{1'b1, 1'b0, 2'd0, 8'h00, 2'b00, 2'b11, 8'hFE};
        tbl[16] = '{1'b1, 1'b0, 2'd1, 8'h00, 2'b10, 2'b01, 8'hFC};
        tbl[17] = '{1'b1, 1'b0, 2'd1, 8'h00, 2'b10, 2'b01, 8'hFE};
        tbl[18] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'b11, 2'b01, 8'hFF};
        tbl[19] = '{1'b1, 1'b1, 2'd0, 8'h03, 2'b11, 2'b01, 8'hFF};
        tbl[20] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'b11, 2'b01, 8'hFF};
        tbl[21] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'b10, 2'b01, 8'hFF};
        tbl[22] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'b11, 2'b00, 8'hFF};

        rst = 1'b1; cpu_cen = 1'b1; trig = 2'b00;
        idle();
        model_reset();
        do_reset(3);
        chk("rst_int_n", {6'd0, int_n0}, 8'h03);
        chk("rst_ctrl", ctrl0, 8'h00);
        chk("rst_dout", dout0, 8'hFF);
        chk("rst_wdog", {7'd0, wd0}, 8'h00);

        // Directed vectors against u0 (no prescaling)
        foreach (tbl[i]) begin
            cs = tbl[i].cs; wr = tbl[i].wr; addr = tbl[i].addr;
            din = tbl[i].din; trig = tbl[i].trig;
            cyc();
            chk($sformatf("vec%0d_int_n", i), {6'd0, int_n0}, {6'd0, tbl[i].e_int});
            chk($sformatf("vec%0d_dout", i), dout0, tbl[i].e_dout);
        end
        idle(); trig = 2'b00;
        chk("vec_ctrl", ctrl0, 8'hA5);

        // Prescaler on u1 channel 0: every 4th edge
        wreg(2'd0, 8'h00);
        wreg(2'd0, 8'h01);
        pulse0("div_p1", 1'b1); pulse0("div_p2", 1'b1); pulse0("div_p3", 1'b1);
        pulse0("div_p4", 1'b0);
        wreg(2'd2, 8'h01);
        chk("div_ack", {7'd0, int_n1[0]}, 8'h01);
        pulse0("div_q1", 1'b1); pulse0("div_q2", 1'b1); pulse0("div_q3", 1'b1);
        pulse0("div_q4", 1'b0);
        wreg(2'd2, 8'h01);
        pulse0("div_r1", 1'b1); pulse0("div_r2", 1'b1);
        wreg(2'd0, 8'h00);
        wreg(2'd0, 8'h01);
        pulse0("div_m1", 1'b1); pulse0("div_m2", 1'b1); pulse0("div_m3", 1'b1);
        pulse0("div_m4", 1'b0);
        wreg(2'd2, 8'h01);
        pulse0("div_s1", 1'b1); pulse0("div_s2", 1'b1);
        do_reset(2);
        wreg(2'd0, 8'h01);
        pulse0("div_t1", 1'b1); pulse0("div_t2", 1'b1); pulse0("div_t3", 1'b1);
        pulse0("div_t4", 1'b0);

        // Watchdog: cpu_cen every 4 clks, no kicks
        do_reset(2);
        for (int n = 1; n <= 40; n++) begin
            cpu_cen = 1'b0;
            repeat (3) cyc();
            cpu_cen = 1'b1;
            cyc();
            chk($sformatf("wdog_free_%0d", n), {7'd0, wd1}, {7'd0, (n == 16 || n == 32)});
        end
        // Kick after the counter has reached 10
        do_reset(2);
        for (int n = 1; n <= 30; n++) begin
            cpu_cen = 1'b0;
            repeat (3) cyc();
            cpu_cen = 1'b1;
            if (n == 11) begin
                cs = 1'b1; wr = 1'b1; addr = 2'd3; din = 8'h5A;
            end
            cyc();
            idle();
            chk($sformatf("wdog_kick_%0d", n), {7'd0, wd0}, {7'd0, (n == 27)});
        end

        // Randomized traffic against the model
        do_reset(2);
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            cpu_cen = ($urandom_range(0, 2) != 0);
            cs      = ($urandom_range(0, 1) != 0);
            wr      = ($urandom_range(0, 2) == 0);
            addr    = 2'($urandom_range(0, 3));
            din     = 8'($urandom);
            if ($urandom_range(0, 3) == 0) trig = 2'($urandom);
            cyc();
        end
        rst = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtkicker_intctl.md
# jtkicker_intctl

Parametrised interrupt and control-latch block for the main CPU of the Konami-style boards. It replaces ad-hoc pairs of edge flip-flops and a flip/clear latch with one unit. The unit provides CH edge-triggered interrupt channels, per-channel frame prescaling, write-1-to-clear acknowledge, a general control latch and a watchdog. It sits between the address decoder and the 6809 interrupt pins (nIRQ/nFIRQ/nNMI).

## Interface
Parameters:
- CH, 2: number of interrupt channels, 1..8.
- TRIG_DIV, {CH{4'd0}}: CH×4-bit vector. Nibble k = n means channel k sets pending on every (n+1)-th qualifying edge.
- WDOG_W, 16: watchdog counter width, 4..24.
- WDOG_EN, 1: 0 removes the watchdog; wdog_rst is then tied to 0.

Ports:
- clk  in  1  system clock (24 MHz)
- rst  in  1  synchronous, active-high reset
- cpu_cen  in  1  CPU bus clock enable; all register writes and watchdog counting are qualified by it
- cs  in  1  block select from the address decoder
- wr  in  1  write strobe (active high, i.e. ~RnW)
- addr  in  2  register select
- din  in  8  CPU write data
- dout  out  8  registered read data
- trig  in  CH  interrupt trigger levels (e.g. ~LVBL, V16)
- int_n  out  CH  active-low interrupt outputs, int_n[k] = ~pending[k]
- ctrl  out  8  general control latch (bit0 flip, others board-specific)
- wdog_rst  out  1  one-clk watchdog expiry pulse

## Operation
- Registers:
  - addr 0 W: mask[CH-1:0] = din[CH-1:0].
  - addr 1 W: ctrl = din.
  - addr 2 W: ack. For each k with din[k]=1, pending[k] is cleared.
  - addr 3 W: watchdog kick, data ignored.
  - Writes occur on clk when cs & wr & cpu_cen.
- Reads (cs & ~wr): addr 0 → {ones, mask}; addr 1 → {ones, pending}; addr 2 → ctrl; addr 3 → 8'hFF. Unused upper bits read 1.
- Edge detection: trig_l <= trig every clk. Qualifying edge on k = trig[k] & ~trig_l[k] & mask[k].
- Prescaler per channel, 4-bit counter divcnt[k]:
  - On a qualifying edge, if divcnt[k] == TRIG_DIV[k], then pending[k] <= 1 and divcnt[k] <= 0.
  - Otherwise divcnt[k] increments.
- Mask bit 0: pending[k] and divcnt[k] are forced to 0 and held there every clk while masked. This gives the same semantics as the old irq_clrn/nmi_clrn latches.
- Priority per channel, highest first:
  1. rst
  2. mask=0 (clear)
  3. prescaled edge (set)
  4. ack (clear)
  
  An edge coinciding with an ack therefore leaves pending=1, so no interrupt is lost.
- Watchdog (WDOG_EN=1):
  - wcnt increments on each cpu_cen.
  - A kick write sets wcnt to 0; the kick wins over the increment.
  - When wcnt is all-ones and cpu_cen is high, wdog_rst pulses for 1 clk and wcnt wraps to 0.
  - wdog_rst does not reset this block; the top level routes it.

## Timing
- Reset values: mask=0, ctrl=0, pending=0, int_n all 1, divcnt=0, trig_l=0, wcnt=0, wdog_rst=0, dout=8'hFF.
- Edge to interrupt: trig rises before posedge N → int_n[k] low after posedge N (0-clk registered latency, 1 flop).
- Write to effect: register updated at the posedge where cs&wr&cpu_cen. int_n rises after that same edge for ack/mask clears.
- dout: registered every clk from current addr/cs. Valid 1 clk after addr is stable, which is well within a 6809 E cycle. When ~cs, dout=8'hFF.
- trig held high produces one event only. A new edge requires trig to go low for at least 1 clk.
- Unmasking while trig is already high produces no event. The next rising edge is required.
- Reset asserted mid-count clears prescalers, so the first post-reset event needs a full TRIG_DIV+1 edges.

## Test plan
- Reset check: hold rst 3 clks → int_n=all 1, ctrl=0, dout=FF, wdog_rst=0. Write mask=01, pulse trig[0] → int_n[0]=0 on the same clk edge.
- Ack vs mask: set mask=03, pulse trig[1].
  - Write ack din=02 → int_n[1]=1.
  - Pulse trig[1] again, then write mask=01 → int_n[1]=1. Further trig[1] pulses are ignored.
- Simultaneous events: ack din=01 on the same clk as a trig[0] rising edge → pending[0] stays 1 and int_n[0]=0.
- Prescaler: TRIG_DIV nibble0=3, mask=01.
  - 3 trig[0] pulses → int_n[0]=1; 4th pulse → 0.
  - Ack, then 4 more pulses → 0 again.
  - Clearing the mask after 2 pulses restarts the count.
- Watchdog: WDOG_W=4, cpu_cen every 4 clks, no kicks → wdog_rst one-clk pulse on the 16th cpu_cen, then every 16 cpu_cen. A kick at count 10 delays the pulse until 16 cpu_cen after the kick.
- Readback: write mask=02, ctrl=A5; read addr0=FE (CH=2 → {6'h3F,2'b10}), addr2=A5, addr1 reflects pending, addr3=FF.
